// File: rtl/grf_scoreboard.sv
// grf_scoreboard: general register file with write-to-read bypass and a
// per-register pending-write scoreboard for decode-stage hazard detection.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   A1/A2, RD1/RD2   two combinational read ports, bypassed from the write port
//   BUSY1/BUSY2      read register still owes a write after this cycle's retire
//   IE, IA, IREADY   issue of an instruction that will write IA; accepted when
//                    IA's pending counter is not saturated
//   WE, A3, WD       retiring write from writeback
//   PC               PC of the writing instruction, used only by the write trace
module grf_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PEND_W = 2,
  parameter int unsigned TRACE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY1,
  output logic              BUSY2,
  input  logic              IE,
  input  logic [ADDR_W-1:0] IA,
  output logic              IREADY,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  input  logic [31:0]       PC
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  // Storage starts cleared so the block is usable before the first reset.
  logic [DATA_W-1:0] regs [DEPTH] = '{default: '0};
  logic [PEND_W-1:0] cnt  [DEPTH] = '{default: '0};

  logic commit;  // write to a non-zero register
  logic issue;   // accepted issue to a non-zero register
  logic retire;  // write that retires a tracked pending entry
  logic dec1;
  logic dec2;

  // Read ports, bypass, busy and issue-ready are all zero-latency.
  always_comb begin
    commit = WE && (A3 != '0);
    IREADY = (IA == '0) || (cnt[IA] != CNT_MAX);
    issue  = IE && IREADY && (IA != '0);
    retire = commit && (cnt[A3] != '0);
    dec1   = retire && (A3 == A1);
    dec2   = retire && (A3 == A2);
    RD1    = (commit && (A3 == A1)) ? WD : regs[A1];
    RD2    = (commit && (A3 == A2)) ? WD : regs[A2];
    // A same-cycle issue belongs to a younger instruction, so only the
    // retiring write is folded into the busy view.
    BUSY1  = (A1 != '0) && ((cnt[A1] - PEND_W'(dec1)) != '0);
    BUSY2  = (A2 != '0) && ((cnt[A2] - PEND_W'(dec2)) != '0);
  end

  // Register and counter update; issue and retire on the same register cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[ADDR_W'(i)] <= '0;
        cnt[ADDR_W'(i)]  <= '0;
      end
    end else begin
      if (commit) begin
        regs[A3] <= WD;
      end
      if (issue && !(retire && (IA == A3))) begin
        cnt[IA] <= cnt[IA] + PEND_W'(1);
      end
      if (retire && !(issue && (IA == A3))) begin
        cnt[A3] <= cnt[A3] - PEND_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  // Simulation-only trace of every committed write.
  always_ff @(posedge clk) begin
    if ((TRACE != 0) && !reset && commit) begin
      $write("@%h: $%0d <= %h\n", PC, A3, WD);
    end
  end
`endif

endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Parametrised general register file with internal write-to-read bypass and a per-register pending-write scoreboard. It sits in the decode stage of the pipelined CPU. It serves two read operands per cycle and accepts one retiring write per cycle. It tracks how many in-flight instructions still owe a write to each register, so that hazard logic can stall on `busy` without keeping its own copy of destination registers.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2**ADDR_W registers
- `PEND_W`, 2, width of each pending-write counter; max outstanding writes per register = 2**PEND_W-1
- `TRACE`, 1, when 1, emits the simulation-only write trace `@<pc hex>: $<addr dec> <= <data hex>` on every committed write

Ports (clock and reset first):
- `clk` input 1: the block uses one clock, and all state updates on its rising edge
- `reset` input 1: reset is synchronous and active-high
- `A1` input ADDR_W: read address, port 1
- `A2` input ADDR_W: read address, port 2
- `RD1` output DATA_W: read data, port 1, with bypass
- `RD2` output DATA_W: read data, port 2, with bypass
- `BUSY1` output 1: register `A1` still has an outstanding write after this cycle's write is accounted for
- `BUSY2` output 1: same as `BUSY1`, for `A2`
- `IE` input 1: issue-enable; an instruction that will write `IA` enters the pipeline
- `IA` input ADDR_W: destination register of the issuing instruction
- `IREADY` output 1: the pending counter of `IA` is not saturated, so the issue is accepted
- `WE` input 1: write-enable from writeback
- `A3` input ADDR_W: write address
- `WD` input DATA_W: write data
- `PC` input 32: PC of the writing instruction, used only for the trace

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus 2**ADDR_W counters of PEND_W bits. Register 0 is hard-wired to zero:
  - writes to it are dropped, with no trace line
  - it never becomes busy
  - `IE` with `IA`=0 is ignored, and `IREADY`=1
- Read: `RDn` = `WD` when `WE` && `A3`==`An` && `A3`!=0. Otherwise `RDn` = `regs[An]`. Purely combinational, zero latency.
- Write commit: when `WE` && `A3`!=0, `regs[A3]` <= `WD` at the clock edge, and the trace line is printed when TRACE=1.
- Pending counter `cnt[r]` update per edge (r != 0):
  - inc = `IE` && `IREADY` && `IA`==r
  - dec = `WE` && `A3`==r && `cnt[r]`!=0
  - next = `cnt[r]` + inc - dec. Simultaneous inc and dec on the same register leaves the counter unchanged.
  - A write to a register whose count is 0 is an untracked write. It commits normally and the counter stays 0 (no underflow).
- `IREADY` = (`IA`==0) || (`cnt[IA]` != all-ones). When `IE` && !`IREADY`, the issue is rejected, the counter is unchanged, and the upstream stage holds.
- `BUSYn` = (`cnt[An]` - decn) != 0, where decn = `WE` && `A3`==`An` && `cnt[An]`!=0. `BUSYn` is forced to 0 for `An`=0.
  - A register whose last outstanding write retires this cycle reads as not busy, with data supplied by the bypass.
  - Same-cycle `IE` to `An` does not affect `BUSYn`; that issue belongs to a younger instruction.

## Timing
- Reset has priority over `WE` and `IE`. On the edge with `reset`=1, all registers and counters clear to 0.
- Outputs following reset:
  - `RD1`/`RD2` = 0 unless bypassing
  - `BUSY1`/`BUSY2` = 0
  - `IREADY` = 1
- Reset mid-operation discards all pending counts. Writes arriving after reset are untracked.
- Initial contents at time 0 are all zero, including counters, even before the first reset.
- Read, bypass, `BUSY` and `IREADY` are combinational, with 0-cycle latency.
- Write and counter effects are visible to the non-bypass path from the cycle after the edge.
- No multicycle paths. No handshake beyond `IE`/`IREADY` sampled on the same edge.

## Test plan
- **Reset.** Write 0x1234 to $5, assert `reset` one cycle, then read `A1`=5. Required: `RD1`=0, `BUSY1`=0, and no trace line for the reset cycle.
- **Bypass and $0.**
  - `WE`=1, `A3`=7, `WD`=0xDEADBEEF, `A1`=7 in the same cycle. Required: `RD1`=0xDEADBEEF before the edge, and `regs[7]`=0xDEADBEEF after it.
  - `WE`=1, `A3`=0, `WD`=0xFFFFFFFF. Required: `RD1`=0 with `A1`=0, and no trace line.
- **Scoreboard lifecycle.**
  - Issue `IA`=3 twice. Required: `BUSY1`=1 with `A1`=3.
  - First write to $3. Required: `BUSY1` stays 1.
  - Second write to $3 (0x55). Required: `BUSY1`=0 in that same cycle and `RD1`=0x55.
- **Saturation.** With PEND_W=2, issue `IA`=9 three times. Required: `IREADY`=0 on the fourth attempt and the count stays 3. Then one write to $9. Required: `IREADY`=1.
- **Simultaneous issue and write.** `cnt[4]`=1; in the same cycle `IE` with `IA`=4 and `WE` with `A3`=4. Required: count stays 1, `BUSY`(A=4)=0 in that cycle, and 1 in the next.
- **Untracked write.** `WE` to $12 with `cnt[12]`=0. Required: data commits, count stays 0 (no wrap to 3), and `BUSY`=0.
